// File: rtl/mux16_arb_pkg.sv
// Shared types and constants for the 16-lane round-robin mux arbiter.
package mux16_arb_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        SWITCH
    } arb_state_t;

    // Width of the hold counter; at least one bit so MAX_HOLD of 1 or 2 still elaborates.
    function automatic int hold_cnt_width(input int max_hold);
        return (max_hold <= 2) ? 1 : $clog2(max_hold);
    endfunction

endpackage

// File: rtl/MuxX16.sv
// Existing 16:1 bit-select mux used unchanged by the arbiter datapath.
module MuxX16 (
    input  logic [15:0] data,
    input  logic [3:0]  sel,
    output logic        out
);

    assign out = data[sel];

endmodule

// File: rtl/mux16_rr_pick.sv
// Rotate-priority picker: first set request strictly after ptr, wrapping 15 -> 0.
module mux16_rr_pick
    import mux16_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
        found = 1'b0;
        idx   = ptr;
        // k == N_REQ wraps to ptr itself, so the previous owner is checked last.
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req[ptr + SEL_W'(k)]) begin
                found = 1'b1;
                idx   = ptr + SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin owner sequencer for the MuxX16 datapath with hold limit and one dead cycle per handover.
// Define MUX16_ARB_LOCK_EN to add the lock input that suppresses hold-limit expiry.
module mux16_rr_arbiter
    import mux16_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] data_in,
`ifdef MUX16_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             data_out,
    output logic             data_valid
);

    localparam int            HW        = hold_cnt_width(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_d;
    logic [SEL_W-1:0] sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             found;
    logic [SEL_W-1:0] win;
    logic             mux_bit;
    logic             others_req;
    logic             lock_hold;

    mux16_rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (found),
        .idx   (win)
    );

    MuxX16 u_mux (
        .data (data_in),
        .sel  (sel),
        .out  (mux_bit)
    );

    assign others_req = |(req & ~gnt);
    assign busy       = (state_q != IDLE);

`ifdef MUX16_ARB_LOCK_EN
    assign lock_hold = lock & req[sel];
`else
    assign lock_hold = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt;
        sel_d   = sel;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE, SWITCH: begin
                if (found) begin
                    state_d = OWN;
                    gnt_d   = N_REQ'(1) << win;
                    sel_d   = win;
                    ptr_d   = win;
                    hold_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                // Release takes precedence over expiry; both lead to the same dead cycle.
                if (!req[sel]) begin
                    state_d = SWITCH;
                    gnt_d   = '0;
                end else if (hold_q == HOLD_LAST) begin
                    if (lock_hold) begin
                        hold_d = hold_q;
                    end else if (others_req) begin
                        state_d = SWITCH;
                        gnt_d   = '0;
                    end else begin
                        hold_d = '0;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: all state registers use non-blocking '<=' so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            gnt        <= '0;
            sel        <= '0;
            ptr_q      <= SEL_W'(N_REQ - 1);
            hold_q     <= '0;
            data_out   <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt        <= gnt_d;
            sel        <= sel_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            data_out   <= mux_bit;
            data_valid <= |gnt;
        end
    end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench for mux16_rr_arbiter: vector table, hand-written corner sequences,
// and randomized traffic against a behavioural owner/turn model.
module tb_mux16_rr_arbiter;

    localparam int MAX_HOLD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = '0;
    logic [15:0] data_in = '0;
    logic        lock = 1'b0;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        busy, data_out, data_valid;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mux16_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data_in    (data_in),
`ifdef MUX16_ARB_LOCK_EN
        .lock       (lock),
`endif
        .gnt        (gnt),
        .sel        (sel),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    // Behavioural model: who owns the mux, for how many cycles, and whether a gap is pending.
    int          m_owner;
    int          m_last;
    int          m_sel;
    int          m_held;
    bit          m_gap;
    logic        e_dout, e_dv;

    typedef struct {
        logic [15:0] req;
        logic [15:0] data;
        logic [15:0] gnt;
        logic [3:0]  sel;
        logic        busy;
        logic        dout;
        logic        dv;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_last  = 15;
        m_sel   = 0;
        m_held  = 0;
        m_gap   = 1'b0;
        e_dout  = 1'b0;
        e_dv    = 1'b0;
    endfunction

    function automatic void model_pick();
        m_gap = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            int c;
            c = (m_last + k) % 16;
            if (req[c]) begin
                m_owner = c;
                m_last  = c;
                m_sel   = c;
                m_held  = 1;
                break;
            end
        end
    endfunction

    function automatic void model_edge();
        e_dout = data_in[m_sel];
        e_dv   = (m_owner >= 0);
        if (m_owner >= 0) begin
            bit lk, others;
            lk     = lock && req[m_owner];
            others = (req & ~(16'(1) << m_owner)) != 16'h0;
            if (!req[m_owner] || (m_held >= MAX_HOLD && others && !lk)) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end else if (m_held >= MAX_HOLD) begin
                m_held = lk ? MAX_HOLD : 1;
            end else begin
                m_held++;
            end
        end else begin
            model_pick();
        end
    endfunction

    task automatic compare_model();
        check("gnt",  gnt, (m_owner >= 0) ? (16'(1) << m_owner) : 16'h0);
        check("sel",  16'(sel), 16'(m_sel));
        check("busy", 16'(busy), 16'((m_owner >= 0) || m_gap));
        check("data_out", 16'(data_out), 16'(e_dout));
        check("data_valid", 16'(data_valid), 16'(e_dv));
    endtask

    task automatic cycle(input logic [15:0] r, input logic [15:0] d, input bit cmp);
        req     = r;
        data_in = d;
        @(posedge clk);
        model_edge();
        #1;
        if (cmp) compare_model();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        req     = '0;
        lock    = 1'b0;
        #2;
        check("rst_gnt", gnt, 16'h0);
        check("rst_sel", 16'(sel), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_dout", 16'(data_out), 16'h0);
        check("rst_dv", 16'(data_valid), 16'h0);
        rst = 1'b0;
        model_reset();
    endtask

    // Grant invariants sampled on the inactive edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("inv_onehot", 16'($onehot0(gnt)), 16'h1);
            if (gnt != 16'h0) begin
                check("inv_gnt_sel", gnt, 16'(1) << sel);
                check("inv_busy", 16'(busy), 16'h1);
            end
        end
    end

    vec_t tbl [8];

    initial begin
        tbl[0] = '{16'h8001, 16'h0001, 16'h0001, 4'd0,  1'b1, 1'b1, 1'b0};
        tbl[1] = '{16'h8000, 16'h0001, 16'h0000, 4'd0,  1'b1, 1'b1, 1'b1};
        tbl[2] = '{16'h8000, 16'h0000, 16'h8000, 4'd15, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{16'h0000, 16'h8000, 16'h0000, 4'd15, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{16'h0000, 16'h0000, 16'h0000, 4'd15, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{16'h0001, 16'hFFFF, 16'h0001, 4'd0,  1'b1, 1'b1, 1'b0};
        tbl[6] = '{16'h0000, 16'h0000, 16'h0000, 4'd0,  1'b1, 1'b0, 1'b1};
        tbl[7] = '{16'h0000, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0, 1'b0};

        model_reset();
        do_reset();

        // Single grant, release handover, idle return and pointer wrap.
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].req, tbl[i].data, 1'b0);
            check("tbl_gnt",  gnt, tbl[i].gnt);
            check("tbl_sel",  16'(sel), 16'(tbl[i].sel));
            check("tbl_busy", 16'(busy), 16'(tbl[i].busy));
            check("tbl_dout", 16'(data_out), 16'(tbl[i].dout));
            check("tbl_dv",   16'(data_valid), 16'(tbl[i].dv));
        end

        // All requesting: 8 cycles per owner, one gap, order 0..15 then 0 again.
        do_reset();
        for (int k = 0; k <= 16 * 9; k++) begin
            cycle(16'hFFFF, 16'($urandom), 1'b1);
            check("rr_order", gnt, ((k % 9) < 8) ? (16'(1) << ((k / 9) % 16)) : 16'h0);
        end

        // Sole requester is never forced off.
        do_reset();
        for (int k = 0; k < 30; k++) begin
            cycle(16'h0004, 16'($urandom), 1'b1);
            check("sole_owner", gnt, 16'h0004);
        end

        // Asynchronous reset in the middle of an ownership.
        do_reset();
        for (int k = 0; k < 3; k++) cycle(16'h0008, 16'h0000, 1'b1);
        check("pre_rst_gnt", gnt, 16'h0008);
        #2;
        rst = 1'b1;
        #1;
        check("async_gnt", gnt, 16'h0);
        check("async_busy", 16'(busy), 16'h0);
        rst = 1'b0;
        model_reset();
        cycle(16'h0009, 16'h0000, 1'b1);
        check("post_rst_gnt", gnt, 16'h0001);

`ifdef MUX16_ARB_LOCK_EN
        do_reset();
        lock = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle(16'h0006, 16'h0000, 1'b1);
            check("lock_hold", gnt, 16'h0002);
        end
        lock = 1'b0;
        cycle(16'h0006, 16'h0000, 1'b1);
        check("lock_gap", gnt, 16'h0000);
        cycle(16'h0006, 16'h0000, 1'b1);
        check("lock_next", gnt, 16'h0004);
`endif

        // Randomized traffic with occasional request reshuffles.
        do_reset();
        begin
            logic [15:0] r;
            r = '0;
            for (int k = 0; k < 800; k++) begin
                if ($urandom_range(3) == 0) begin
                    r = ($urandom_range(5) == 0) ? 16'h0 : 16'($urandom & $urandom);
                end
`ifdef MUX16_ARB_LOCK_EN
                lock = ($urandom_range(3) == 0);
`endif
                cycle(r, 16'($urandom), 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
